// File: rtl/wb_sram16_ctrl.sv
// Wishbone classic slave bridging 32-bit accesses onto an asynchronous 16-bit SRAM.
// Each word is split into up to two half-word cycles with programmable wait states.
module wb_sram16_ctrl #(
  parameter int ADDR_W   = 19,
  parameter int WAIT_CYC = 2,
  parameter int TURN_CYC = 1
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic [31:0]       wb_adr_i,
  input  logic [31:0]       wb_dat_i,
  output logic [31:0]       wb_dat_o,
  input  logic [3:0]        wb_sel_i,
  input  logic              wb_we_i,
  input  logic              wb_stb_i,
  input  logic              wb_cyc_i,
  output logic              wb_ack_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  inout  wire  [15:0]       sram_dq_io,
  output logic              sram_ce_n_o,
  output logic              sram_oe_n_o,
  output logic              sram_we_n_o,
  output logic              sram_lb_n_o,
  output logic              sram_ub_n_o
);

  // state    | meaning
  // IDLE     | waiting for cyc&stb, request latched on accept
  // LO_SETUP | low half-word: address/lanes/ce valid, we_n high
  // LO_ACC   | low half-word access, WAIT_CYC cycles
  // HI_SETUP | high half-word: address/lanes/ce valid, we_n high
  // HI_ACC   | high half-word access, WAIT_CYC cycles
  // ACK      | one-cycle acknowledge, strobes inactive
  // TURN     | bus turnaround after a write, requests ignored
  typedef enum logic [2:0] {
    IDLE, LO_SETUP, LO_ACC, HI_SETUP, HI_ACC, ACK, TURN
  } state_t;

  localparam logic [7:0] WAIT_LD = 8'(WAIT_CYC - 1);
  localparam logic [7:0] TURN_LD = 8'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);

  state_t            state;
  logic [7:0]        cnt;
  logic [ADDR_W-2:0] adr_q;
  logic [31:0]       dat_q;
  logic [3:0]        sel_q;
  logic              we_q;
  logic [15:0]       rd_lo;
  logic              dq_oe;
  logic [15:0]       dq_out;

  logic unused_adr;
  assign unused_adr = ^{wb_adr_i[31:ADDR_W+1], wb_adr_i[1:0]};

  assign sram_dq_io = dq_oe ? dq_out : 16'hzzzz;

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      state       <= IDLE;
      cnt         <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      rd_lo       <= '0;
      wb_ack_o    <= 1'b0;
      wb_dat_o    <= '0;
      sram_addr_o <= '0;
      sram_ce_n_o <= 1'b1;
      sram_oe_n_o <= 1'b1;
      sram_we_n_o <= 1'b1;
      sram_lb_n_o <= 1'b1;
      sram_ub_n_o <= 1'b1;
      dq_oe       <= 1'b0;
      dq_out      <= '0;
    end else begin
      wb_ack_o <= 1'b0;
      if (!wb_cyc_i && state != IDLE && state != ACK) begin
        // master abandoned the cycle: release the SRAM without acking
        state       <= IDLE;
        cnt         <= '0;
        sram_ce_n_o <= 1'b1;
        sram_oe_n_o <= 1'b1;
        sram_we_n_o <= 1'b1;
        sram_lb_n_o <= 1'b1;
        sram_ub_n_o <= 1'b1;
        dq_oe       <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (wb_cyc_i && wb_stb_i) begin
              adr_q <= wb_adr_i[ADDR_W:2];
              dat_q <= wb_dat_i;
              sel_q <= wb_sel_i;
              we_q  <= wb_we_i;
              rd_lo <= '0;
              if (|wb_sel_i[1:0]) begin
                state       <= LO_SETUP;
                sram_addr_o <= {wb_adr_i[ADDR_W:2], 1'b0};
                sram_lb_n_o <= ~wb_sel_i[0];
                sram_ub_n_o <= ~wb_sel_i[1];
                sram_ce_n_o <= 1'b0;
                sram_oe_n_o <= wb_we_i;
                dq_oe       <= wb_we_i;
                dq_out      <= wb_dat_i[15:0];
              end else if (|wb_sel_i[3:2]) begin
                state       <= HI_SETUP;
                sram_addr_o <= {wb_adr_i[ADDR_W:2], 1'b1};
                sram_lb_n_o <= ~wb_sel_i[2];
                sram_ub_n_o <= ~wb_sel_i[3];
                sram_ce_n_o <= 1'b0;
                sram_oe_n_o <= wb_we_i;
                dq_oe       <= wb_we_i;
                dq_out      <= wb_dat_i[31:16];
              end else begin
                state    <= ACK;
                wb_ack_o <= 1'b1;
                if (!wb_we_i) wb_dat_o <= '0;
              end
            end
          end
          LO_SETUP, HI_SETUP: begin
            state       <= (state == LO_SETUP) ? LO_ACC : HI_ACC;
            cnt         <= WAIT_LD;
            sram_we_n_o <= ~we_q;
          end
          LO_ACC: begin
            if (cnt != 8'd0) begin
              cnt <= cnt - 8'd1;
            end else begin
              sram_we_n_o <= 1'b1;
              if (|sel_q[3:2]) begin
                // read oe_n stays low straight into the high phase
                state       <= HI_SETUP;
                if (!we_q) rd_lo <= sram_dq_io;
                sram_addr_o <= {adr_q, 1'b1};
                sram_lb_n_o <= ~sel_q[2];
                sram_ub_n_o <= ~sel_q[3];
                dq_out      <= dat_q[31:16];
              end else begin
                state       <= ACK;
                wb_ack_o    <= 1'b1;
                if (!we_q) wb_dat_o <= {16'h0000, sram_dq_io};
                sram_ce_n_o <= 1'b1;
                sram_oe_n_o <= 1'b1;
                sram_lb_n_o <= 1'b1;
                sram_ub_n_o <= 1'b1;
                dq_oe       <= 1'b0;
              end
            end
          end
          HI_ACC: begin
            if (cnt != 8'd0) begin
              cnt <= cnt - 8'd1;
            end else begin
              state       <= ACK;
              wb_ack_o    <= 1'b1;
              if (!we_q) wb_dat_o <= {sram_dq_io, rd_lo};
              sram_ce_n_o <= 1'b1;
              sram_oe_n_o <= 1'b1;
              sram_we_n_o <= 1'b1;
              sram_lb_n_o <= 1'b1;
              sram_ub_n_o <= 1'b1;
              dq_oe       <= 1'b0;
            end
          end
          ACK: begin
            if (we_q && TURN_CYC > 0) begin
              state <= TURN;
              cnt   <= TURN_LD;
            end else begin
              state <= IDLE;
            end
          end
          TURN: begin
            if (cnt != 8'd0) cnt <= cnt - 8'd1;
            else state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/wb_sram16_ctrl.md
Name: wb_sram16_ctrl

Overview:
- Wishbone classic slave that bridges the 32-bit SOPC data bus to an external asynchronous 16-bit SRAM (for example IS61WV-class parts).
- Sits directly downstream of the Wishbone crossbar on a free slave slot (s4), alongside the SDRAM, UART, GPIO and flash slaves.
- Each 32-bit access is split into up to two half-word SRAM cycles with programmable wait states.

Parameters:
ADDR_W, 19, external half-word address width (sram_addr_o width)
WAIT_CYC, 2, access cycles per half-word (>=1)
TURN_CYC, 1, idle cycles inserted after a write transaction before the next accept (0 allowed)

Ports:
wb_clk_i  in  1  single clock for all logic
wb_rst_i  in  1  reset, asynchronous, active-low
wb_adr_i  in  32  byte address; bits [ADDR_W:2] used
wb_dat_i  in  32  write data
wb_dat_o  out  32  read data
wb_sel_i  in  4  byte lane enables
wb_we_i  in  1  1=write
wb_stb_i  in  1  strobe
wb_cyc_i  in  1  cycle valid
wb_ack_o  out  1  one-cycle acknowledge
sram_addr_o  out  ADDR_W  half-word address
sram_dq_io  inout  16  data bus, driven only during write setup/access
sram_ce_n_o  out  1  chip enable
sram_oe_n_o  out  1  output enable
sram_we_n_o  out  1  write enable
sram_lb_n_o  out  1  lower byte enable (dq[7:0])
sram_ub_n_o  out  1  upper byte enable (dq[15:8])

Behaviour:
- Reset (async, wb_rst_i=0):
  - wb_ack_o=0, wb_dat_o=0, sram_addr_o=0.
  - ce_n/oe_n/we_n/lb_n/ub_n=1, dq tri-stated.
  - FSM=IDLE and wait counter=0, immediately, including mid-write (we_n rises with reset).
- Address and lane mapping:
  - Phase LO: half-word address {wb_adr_i[ADDR_W:2],0}, data wb_dat_i[15:0], lb_n=~sel[0], ub_n=~sel[1].
  - Phase HI: half-word address {wb_adr_i[ADDR_W:2],1}, data wb_dat_i[31:16], lb_n=~sel[2], ub_n=~sel[3].
  - A phase whose two sel bits are 0 is skipped.
- Request capture: in IDLE, cyc_i&stb_i accepts the request; adr/dat/sel/we are latched and held for the whole transaction.
- FSM states: IDLE, LO_SETUP, LO_ACC, HI_SETUP, HI_ACC, ACK, TURN.
- IDLE transitions on accept:
  - sel[1:0]!=0 -> LO_SETUP.
  - else sel[3:2]!=0 -> HI_SETUP.
  - else (sel=0) -> ACK with no SRAM activity.
- SETUP (1 cycle): addr and lb/ub valid, ce_n=0, we_n=1. Read: oe_n=0. Write: dq driven.
- ACC (WAIT_CYC cycles, counter): ce_n=0 and addr held.
  - Write: we_n=0, dq driven.
  - Read: oe_n=0; dq sampled at the last ACC cycle into the matching wb_dat_o half.
  - LO_ACC exits to HI_SETUP if sel[3:2]!=0, else ACK. HI_ACC exits to ACK.
  - we_n returns to 1 on exit, and addr/dq are stable through that edge.
- ACK (1 cycle):
  - wb_ack_o=1; SRAM strobes inactive.
  - Read: wb_dat_o complete; half-words not accessed read 0.
  - Then TURN if write and TURN_CYC>0 (TURN_CYC cycles, requests not accepted), else IDLE.
- wb_dat_o holds its value until the next read capture.
- Latency: request first seen in IDLE at cycle C0. Ack in cycle:
  - two half-words: C0+2*(1+WAIT_CYC)+1;
  - one half-word: C0+(1+WAIT_CYC)+1;
  - sel=0: C0+1.
- Abort: cyc_i=0 in any non-IDLE, non-ACK state -> next edge IDLE, all strobes inactive, no ack, wb_dat_o unchanged.
- No back-pressure beyond delaying ack; stb_i while busy is ignored.
- dq is never driven while oe_n=0; there is at least one cycle between read oe_n=0 and a following write drive, guaranteed by ACK.

Test Plan:
- Full-word write with WAIT_CYC=2, adr=0x10, sel=1111, dat=0x12345678 -> SRAM half-word 8=0x5678, 9=0x1234; we_n low 2 cycles per phase; ack in C7 only; TURN 1 cycle.
- Read back of 0x10 with sel=1111 -> wb_dat_o=0x12345678 at ack (C7); oe_n low 6 cycles total; dq never driven.
- Byte write adr=0x10, sel=0100, dat=0xAABBCCDD -> HI phase only, lb_n=0, ub_n=1, dq[7:0]=0xBB at half-word 9; ack at C4; a subsequent read returns 0x12BB5678.
- sel=0000 write -> ack at C1; ce_n stays 1 throughout.
- cyc_i dropped during HI_ACC of a read -> no ack, ce_n/oe_n return to 1 next cycle, wb_dat_o keeps its previous value, and the next request is accepted normally.
- wb_rst_i pulsed low mid-LO_ACC write -> we_n/ce_n go 1 asynchronously, dq tri-stated, wb_ack_o=0; after release, a new read completes with correct latency.
